// File: rtl/gb_stream_pkg.sv
// Shared definitions for the ghostbus stream host.
//   - gb_state_e : host FSM states
//   - command byte field positions (write flag, reserved bits, word count)
//   - ab_of/db_of: bytes per address and per data word on the byte stream
package gb_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StWstrobe,
    StRwait,
    StRsend
  } gb_state_e;

  // Command byte layout: [7] write, [6:4] reserved (must be 0), [3:0] words-1.
  localparam int unsigned WR_BIT  = 7;
  localparam int unsigned RSVD_HI = 6;
  localparam int unsigned RSVD_LO = 4;
  localparam int unsigned CNT_HI  = 3;
  localparam int unsigned CNT_LO  = 0;

  // Address bytes on the stream: ceil(aw / 8).
  function automatic int unsigned ab_of(input int unsigned aw);
    return (aw + 7) / 8;
  endfunction

  // Data bytes per word on the stream.
  function automatic int unsigned db_of(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/gb_byte_shreg.sv
// Byte <-> word shift register used for both write assembly and read serialisation.
//   clk_i, rst_i   : clock, asynchronous active-high reset (clears the word)
//   load_byte_i    : shift byte_i in at the LSB end (stream is MSB first)
//   load_word_i    : parallel load of word_i (takes priority)
//   shift_i        : shift left by one byte, zero fill
//   word_o         : current word
//   word_next_o    : word as it will be after a load_byte of byte_i
//   msb_o          : current most-significant byte
module gb_byte_shreg #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_byte_i,
  input  logic [7:0]    byte_i,
  input  logic          load_word_i,
  input  logic [DW-1:0] word_i,
  input  logic          shift_i,
  output logic [DW-1:0] word_o,
  output logic [DW-1:0] word_next_o,
  output logic [7:0]    msb_o
);

  logic [DW-1:0] word_q, word_d;
  logic [DW+7:0] cat_byte;
  logic [DW+7:0] cat_zero;

  // Concatenate then truncate so DW == 8 needs no special-case slice.
  assign cat_byte = {word_q, byte_i};
  assign cat_zero = {word_q, 8'h00};

  assign word_next_o = cat_byte[DW-1:0];
  assign word_o      = word_q;
  assign msb_o       = word_q[DW-1 -: 8];

  always_comb begin
    word_d = word_q;
    if (load_word_i) begin
      word_d = word_i;
    end else if (load_byte_i) begin
      word_d = cat_byte[DW-1:0];
    end else if (shift_i) begin
      word_d = cat_zero[DW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/gb_stream_host.sv
// Byte-stream to ghostbus bridge.
// Packets: cmd byte, ceil(AW/8) address bytes (MSB first), then for writes N data words
// of DW/8 bytes each (MSB first). Reads return N words on the tx stream, MSB first.
//   clk, rst            : clock, asynchronous active-high reset
//   rx_data/valid/ready : command byte stream in
//   tx_data/valid/ready : response byte stream out
//   gb_addr/dout/din/we : ghostbus master (gb_clk is clk)
//   busy                : FSM not idle
//   err                 : one-cycle pulse on a rejected command byte
module gb_stream_host
  import gb_stream_pkg::*;
#(
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  input  logic [DW-1:0] gb_din,
  output logic          gb_we,
  output logic          busy,
  output logic          err
);

  localparam int unsigned AB = ab_of(AW);
  localparam int unsigned DB = db_of(DW);
  localparam logic [2:0] AB_LAST  = 3'(AB - 1);
  localparam logic [2:0] DB_LAST  = 3'(DB - 1);
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  gb_state_e     state_q, state_d;
  logic [AW-1:0] addr_cur_q, addr_cur_d;
  logic [AW-1:0] gb_addr_q, gb_addr_d;
  logic [DW-1:0] gb_dout_q, gb_dout_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    word_cnt_q, word_cnt_d;
  logic          is_wr_q, is_wr_d;
  logic          err_q, err_d;
  logic          rdy_en_q;

  logic          sh_load_byte, sh_load_word, sh_shift;
  logic [DW-1:0] sh_word, sh_word_next;
  logic [7:0]    sh_msb;

  logic          rx_fire, tx_fire;
  logic [AW+7:0] addr_shifted;
  logic [AW-1:0] addr_inc;

  gb_byte_shreg #(
    .DW (DW)
  ) u_shreg (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_byte_i (sh_load_byte),
    .byte_i      (rx_data),
    .load_word_i (sh_load_word),
    .word_i      (gb_din),
    .shift_i     (sh_shift),
    .word_o      (sh_word),
    .word_next_o (sh_word_next),
    .msb_o       (sh_msb)
  );

  // rx_ready is held low until the first edge after reset release.
  assign rx_ready = rdy_en_q &&
                    ((state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata));
  assign tx_valid = (state_q == StRsend);
  assign gb_we    = (state_q == StWstrobe);
  assign busy     = (state_q != StIdle);
  assign err      = err_q;
  assign tx_data  = sh_msb;
  assign gb_addr  = gb_addr_q;
  assign gb_dout  = gb_dout_q;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  // Shifting MSB-first into an AW-wide register drops address bits above AW.
  assign addr_shifted = {addr_cur_q, rx_data};
  assign addr_inc     = addr_cur_q + AW'(1);

  always_comb begin
    state_d      = state_q;
    addr_cur_d   = addr_cur_q;
    gb_addr_d    = gb_addr_q;
    gb_dout_d    = gb_dout_q;
    byte_cnt_d   = byte_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    word_cnt_d   = word_cnt_q;
    is_wr_d      = is_wr_q;
    err_d        = 1'b0;
    sh_load_byte = 1'b0;
    sh_load_word = 1'b0;
    sh_shift     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (rx_data[RSVD_HI:RSVD_LO] != 3'b000) begin
            err_d = 1'b1;
          end else begin
            is_wr_d    = rx_data[WR_BIT];
            word_cnt_d = rx_data[CNT_HI:CNT_LO];
            byte_cnt_d = '0;
            state_d    = StAddr;
          end
        end
      end

      StAddr: begin
        if (rx_fire) begin
          addr_cur_d = addr_shifted[AW-1:0];
          if (byte_cnt_q == AB_LAST) begin
            byte_cnt_d = '0;
            if (is_wr_q) begin
              state_d = StWdata;
            end else begin
              gb_addr_d  = addr_shifted[AW-1:0];
              wait_cnt_d = '0;
              state_d    = StRwait;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end

      StWdata: begin
        if (rx_fire) begin
          sh_load_byte = 1'b1;
          if (byte_cnt_q == DB_LAST) begin
            byte_cnt_d = '0;
            gb_addr_d  = addr_cur_q;
            gb_dout_d  = sh_word_next;
            state_d    = StWstrobe;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end

      StWstrobe: begin
        addr_cur_d = addr_inc;
        if (word_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          word_cnt_d = word_cnt_q - 4'd1;
          state_d    = StWdata;
        end
      end

      StRwait: begin
        if (wait_cnt_q == LAT_LAST) begin
          sh_load_word = 1'b1;
          wait_cnt_d   = '0;
          state_d      = StRsend;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end

      StRsend: begin
        if (tx_fire) begin
          sh_shift = 1'b1;
          if (byte_cnt_q == DB_LAST) begin
            byte_cnt_d = '0;
            addr_cur_d = addr_inc;
            if (word_cnt_q == 4'd0) begin
              state_d = StIdle;
            end else begin
              word_cnt_d = word_cnt_q - 4'd1;
              gb_addr_d  = addr_inc;
              state_d    = StRwait;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_cur_q <= '0;
      gb_addr_q  <= '0;
      gb_dout_q  <= '0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      word_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cur_q <= addr_cur_d;
      gb_addr_q  <= gb_addr_d;
      gb_dout_q  <= gb_dout_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      word_cnt_q <= word_cnt_d;
      is_wr_q    <= is_wr_d;
      err_q      <= err_d;
      rdy_en_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gb_stream_host.sv
// Directed bench for gb_stream_host with scoreboard queues for ghostbus writes and tx bytes.
module tb_gb_stream_host;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] gb_addr;
  logic [31:0] gb_dout;
  logic [31:0] gb_din;
  logic        gb_we;
  logic        busy;
  logic        err;

  logic [31:0] mem [0:4095];
  logic [43:0] wr_q [$];
  logic [7:0]  tx_q [$];

  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_ready = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_tx = 8'h00;

  always #5 clk = ~clk;

  // One-cycle registered RAM on the ghostbus read side.
  always @(posedge clk) gb_din <= mem[gb_addr];

  gb_stream_host #(
    .AW     (12),
    .DW     (32),
    .RD_LAT (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .gb_addr  (gb_addr),
    .gb_dout  (gb_dout),
    .gb_din   (gb_din),
    .gb_we    (gb_we),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  // Called at the falling edge: observes what the next rising edge will act on.
  task automatic monitor();
    logic [43:0] e;
    logic [7:0]  b;
    if (gb_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_we", {31'd0, gb_we}, 32'd0);
      end else begin
        e = wr_q.pop_front();
        check("we_addr", {20'd0, gb_addr}, {20'd0, e[43:32]});
        check("we_data", gb_dout, e[31:0]);
      end
    end
    if (prev_stall) begin
      check("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
      check("tx_stable", {24'd0, tx_data}, {24'd0, prev_tx});
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) begin
        check("unexpected_tx", {31'd0, tx_valid}, 32'd0);
      end else begin
        b = tx_q.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, b});
      end
    end
    prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
    prev_tx    = tx_data;
  endtask

  task automatic tick(output bit rdy);
    @(negedge clk);
    monitor();
    rdy = (rx_ready === 1'b1);
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit hs = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) tick(hs);
    rx_valid = 1'b0;
    if (!hs) check("rx_timeout", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic wait_done();
    bit d;
    for (int n = 0; n < 500; n++) begin
      if (busy === 1'b0 && wr_q.size() == 0 && tx_q.size() == 0) break;
      tick(d);
    end
    check("done_busy", {31'd0, busy}, 32'd0);
    check("wr_left", wr_q.size(), 32'd0);
    check("tx_left", tx_q.size(), 32'd0);
  endtask

  initial begin
    bit d;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h0101_0007;
    mem[12'h010] = 32'h1122_3344;
    mem[12'h011] = 32'h5566_7788;
    mem[12'hFFF] = 32'hA1B2_C3D4;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_gb_we", {31'd0, gb_we}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_gb_addr", {20'd0, gb_addr}, 32'd0);
    check("rst_gb_dout", gb_dout, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rx_ready_before_edge", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rx_ready_after_edge", {31'd0, rx_ready}, 32'd1);

    // Single-word write.
    wr_q.push_back({12'h123, 32'hDEAD_BEEF});
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h23);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_done();

    // Two-word read from the registered RAM.
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    wait_done();

    // Read at top of address space with a stalling consumer.
    rand_ready = 1'b1;
    push_word(32'hA1B2_C3D4);
    send_byte(8'h00); send_byte(8'h0F); send_byte(8'hFF);
    wait_done();
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    check("read_gb_addr", {20'd0, gb_addr}, 32'h0000_0FFF);

    // Two-word write wrapping from 0xFFF to 0x000.
    wr_q.push_back({12'hFFF, 32'hCAFE_F00D});
    wr_q.push_back({12'h000, 32'h0BAD_1DEA});
    send_byte(8'h81); send_byte(8'h0F); send_byte(8'hFF);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    send_byte(8'h0B); send_byte(8'hAD); send_byte(8'h1D); send_byte(8'hEA);
    wait_done();

    // Reserved bits set: rejected, then a normal read.
    send_byte(8'h10);
    check("rej_err_pulse", {31'd0, err}, 32'd1);
    check("rej_busy", {31'd0, busy}, 32'd0);
    tick(d);
    check("rej_err_clear", {31'd0, err}, 32'd0);
    check("rej_busy_after", {31'd0, busy}, 32'd0);
    push_word(32'h1122_3344);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    wait_done();

    // Reset in the middle of write data.
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h23);
    send_byte(8'hDE); send_byte(8'hAD);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_gb_we", {31'd0, gb_we}, 32'd0);
    check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_gb_addr", {20'd0, gb_addr}, 32'd0);
    check("mid_rst_gb_dout", gb_dout, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr_q.push_back({12'h042, 32'h0102_0304});
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h42);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done();

    // Quiet tail: nothing further may appear on either side.
    repeat (5) tick(d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gb_stream_host.md
GB_STREAM_HOST -- requirements
Module: gb_stream_host

Interface
REQ-001 Parameter AW, default 12, ghostbus address width; range 1..32.
REQ-002 Parameter DW, default 32, ghostbus data width; multiple of 8, range 8..32.
REQ-003 Parameter RD_LAT, default 2, cycles from gb_addr presentation to gb_din sampling; range 1..7.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1) and rst (input, 1), both listed first.
REQ-005 clk  input  1  single clock; downstream gb_clk is tied to clk.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 rx_data  input  8  command byte stream.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  block accepts rx_data this cycle.
REQ-010 tx_data  output  8  response byte stream.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  consumer accepts tx_data.
REQ-013 gb_addr  output  AW  ghostbus address.
REQ-014 gb_dout  output  DW  ghostbus write data.
REQ-015 gb_din  input  DW  ghostbus read data.
REQ-016 gb_we  output  1  ghostbus write strobe.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-019 Byte transfers SHALL occur only on cycles where valid and ready are both high.
REQ-020 Packet format SHALL be: cmd byte, then AB=ceil(AW/8) address bytes MSB first, then, for writes only, N words of DB=DW/8 bytes each, MSB first.
REQ-021 cmd[7] SHALL select write (1) or read (0); cmd[3:0] SHALL give N-1, so N ranges 1..16.
REQ-022 cmd[6:4] nonzero SHALL cause a one-cycle err pulse, consumption of the cmd byte only, and a return to IDLE.
REQ-023 Address bits above AW SHALL be discarded.
REQ-024 FSM states SHALL be IDLE, ADDR, WDATA, WSTROBE, RWAIT and RSEND.
REQ-025 IDLE->ADDR on a valid cmd; ADDR->WDATA (write) or ADDR->RWAIT (read) after AB bytes.
REQ-026 WDATA->WSTROBE after DB bytes; in WSTROBE, gb_we=1 for exactly one cycle with gb_addr and gb_dout stable.
REQ-027 After WSTROBE: address increments, count decrements; go to WDATA if words remain, else IDLE.
REQ-028 RWAIT SHALL hold gb_addr with gb_we=0 for RD_LAT cycles, then capture gb_din and enter RSEND.
REQ-029 RSEND SHALL emit DB bytes MSB first, holding tx_data stable while tx_valid && !tx_ready.
REQ-030 After RSEND: address increments, count decrements; go to RWAIT if words remain, else IDLE.
REQ-031 Address increment SHALL wrap modulo 2^AW.
REQ-032 rx_ready SHALL be high only in IDLE, ADDR and WDATA.
REQ-033 tx_valid SHALL be high only in RSEND.
REQ-034 Writes SHALL produce no response bytes.
REQ-035 gb_addr and gb_dout SHALL hold their last values outside strobe and read phases.

Reset
REQ-036 Asserting rst at any time SHALL asynchronously force: IDLE; gb_we, rx_ready, tx_valid, busy and err to 0; gb_addr, gb_dout, tx_data and the internal counters to 0.
REQ-037 A packet interrupted by reset SHALL be abandoned; the first byte accepted after reset is a cmd byte.
REQ-038 rx_ready SHALL rise no earlier than the first clk edge after rst deasserts.

Structure
REQ-039 Package gb_stream_pkg SHALL hold the state enum, the cmd field positions (WR_BIT=7, RSVD=6:4, CNT=3:0) and the AB/DB helper functions.
REQ-040 Sub-module gb_byte_shreg SHALL provide the byte<->word shift register: load byte, load word, shift out MSB.

Verification
REQ-041 Write packet 0x80,0x01,0x23,0xDE,0xAD,0xBE,0xEF -> one gb_we pulse with gb_addr=0x123, gb_dout=0xDEADBEEF; no tx bytes.
REQ-042 Read packet 0x01,0x00,0x10 with gb_din modelled as a 1-cycle registered RAM holding 0x11223344@0x010 and 0x55667788@0x011 -> tx bytes 11,22,33,44,55,66,77,88.
REQ-043 Read packet 0x00,0x0F,0xFF with tx_ready toggling randomly -> gb_addr=0xFFF, all DB bytes delivered in order, tx_data stable while stalled.
REQ-044 Write with N=2 at 0xFFF -> strobes at 0xFFF then 0x000 (wrap).
REQ-045 Cmd byte 0x10 -> err pulses once, busy stays 0, next cmd byte accepted normally.
REQ-046 rst asserted mid-WDATA after 2 data bytes -> no gb_we pulse; all outputs at reset values; a fresh packet completes correctly.
